// File: rtl/spi_ram_arbiter_if.sv
// ----------------------------------------------------------------------------
// spi_ram_arbiter_if
// Requester-side bus of the SPI RAM arbiter. All requesters share one
// flattened bundle; requester i owns bit i of req/op/gnt/done and slice
// [i*ADDR_SIZE +: ADDR_SIZE] of addr/wdata.
//   req   : per-requester transaction request (level, held until gnt)
//   op    : per-requester operation, 0 = write, 1 = read
//   addr  : flattened addresses
//   wdata : flattened write data
//   gnt   : one-hot grant pulse, request fields latched in that cycle
//   done  : one-hot completion pulse to the transaction owner
//   rdata : read data, qualified by done
//   err   : read timeout flag, qualified by done
// Modports: master = requester side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface spi_ram_arbiter_if #(
   parameter int NUM_REQ   = 2,
   parameter int ADDR_SIZE = 8
);
   logic [NUM_REQ-1:0]           req;
   logic [NUM_REQ-1:0]           op;
   logic [NUM_REQ*ADDR_SIZE-1:0] addr;
   logic [NUM_REQ*ADDR_SIZE-1:0] wdata;
   logic [NUM_REQ-1:0]           gnt;
   logic [NUM_REQ-1:0]           done;
   logic [ADDR_SIZE-1:0]         rdata;
   logic                         err;

   modport master (
      output req, op, addr, wdata,
      input  gnt, done, rdata, err
   );

   modport slave (
      input  req, op, addr, wdata,
      output gnt, done, rdata, err
   );
endinterface

// File: rtl/spi_ram_arbiter.sv
// ----------------------------------------------------------------------------
// spi_ram_arbiter
// Round-robin arbiter and command sequencer sharing one SPI-side RAM among
// NUM_REQ requesters. Each granted transaction is expanded into a two-word
// RAM command sequence (00/01 for a write, 10/11 for a read); read data is
// captured and returned with a timeout error if the RAM never answers.
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   bus          : requester bus (slave modport of spi_ram_arbiter_if)
//   busy         : high in every state except IDLE
//   ram_din      : RAM command word {opcode[1:0], payload}
//   ram_rx_valid : RAM command strobe
//   ram_dout     : RAM read data
//   ram_tx_valid : RAM read-valid (may stay high from an earlier read)
// ----------------------------------------------------------------------------
module spi_ram_arbiter #(
   parameter int NUM_REQ   = 2,
   parameter int ADDR_SIZE = 8,
   parameter int TIMEOUT   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   spi_ram_arbiter_if.slave     bus,
   output logic                 busy,
   output logic [ADDR_SIZE+1:0] ram_din,
   output logic                 ram_rx_valid,
   input  logic [ADDR_SIZE-1:0] ram_dout,
   input  logic                 ram_tx_valid
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_CMD_ADDR = 3'd1;
   localparam logic [2:0] S_CMD_DATA = 3'd2;
   localparam logic [2:0] S_WAIT     = 3'd3;
   localparam logic [2:0] S_RESP     = 3'd4;

   logic [2:0]           state;
   logic [IW-1:0]        last;
   logic [CW-1:0]        cnt;
   logic [IW-1:0]        owner;
   logic                 op_r;
   logic [ADDR_SIZE-1:0] addr_r;
   logic [ADDR_SIZE-1:0] wdata_r;
   logic [ADDR_SIZE-1:0] rdata_r;
   logic                 err_r;

   logic                 pick_vld;
   logic [IW-1:0]        pick_idx;
   logic [IW:0]          sum;
   logic [IW-1:0]        cand;
   logic                 sel_op;
   logic [ADDR_SIZE-1:0] sel_addr;
   logic [ADDR_SIZE-1:0] sel_wdata;
   logic                 grant;

   // Arbitration: scan upward from last+1 with wrap. The extra sum bit holds
   // last+k (at most 2*NUM_REQ-1) before the wrap subtraction.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      sum      = '0;
      cand     = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         sum = {1'b0, last} + (IW+1)'(k);
         if (sum >= (IW+1)'(NUM_REQ))
            sum = sum - (IW+1)'(NUM_REQ);
         cand = sum[IW-1:0];
         if (!pick_vld && bus.req[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   // Mux out the winner's request fields with constant slice positions.
   always_comb begin
      sel_op    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (IW'(i) == pick_idx) begin
            sel_op    = bus.op[i];
            sel_addr  = bus.addr[i*ADDR_SIZE +: ADDR_SIZE];
            sel_wdata = bus.wdata[i*ADDR_SIZE +: ADDR_SIZE];
         end
      end
   end

   // Reset gates the combinational pulses so they read as zero while rst is
   // high, even though IDLE already sees live requests.
   assign grant    = (state == S_IDLE) && pick_vld && !rst;
   assign bus.gnt  = grant ? (NUM_REQ'(1) << pick_idx) : '0;
   assign bus.done = ((state == S_RESP) && !rst) ? (NUM_REQ'(1) << owner) : '0;
   assign bus.rdata = rdata_r;
   assign bus.err   = err_r;
   assign busy      = (state != S_IDLE);

   // Command word is a pure function of state so it drops to zero on the
   // same edge that leaves CMD_DATA or applies reset.
   always_comb begin
      ram_rx_valid = 1'b0;
      ram_din      = '0;
      case (state)
         S_CMD_ADDR: begin
            ram_rx_valid = 1'b1;
            ram_din      = {op_r, 1'b0, addr_r};
         end
         S_CMD_DATA: begin
            ram_rx_valid = 1'b1;
            ram_din      = op_r ? {2'b11, {ADDR_SIZE{1'b0}}} : {2'b01, wdata_r};
         end
         default: ;
      endcase
   end

   // Grant boundary: request fields captured when the grant pulses.
   always_ff @(posedge clk) begin
      if (grant) begin
         owner   <= pick_idx;
         op_r    <= sel_op;
         addr_r  <= sel_addr;
         wdata_r <= sel_wdata;
      end
   end

   // Sequencer: IDLE -> CMD_ADDR -> CMD_DATA -> (WAIT) -> RESP -> IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         last    <= IW'(NUM_REQ-1);
         cnt     <= '0;
         rdata_r <= '0;
         err_r   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant) begin
                  last  <= pick_idx;
                  state <= S_CMD_ADDR;
               end
            end
            S_CMD_ADDR: state <= S_CMD_DATA;
            S_CMD_DATA: begin
               if (op_r) begin
                  cnt   <= '0;
                  state <= S_WAIT;
               end else begin
                  rdata_r <= '0;
                  err_r   <= 1'b0;
                  state   <= S_RESP;
               end
            end
            S_WAIT: begin
               // The RAM refreshed dout on the edge ending CMD_DATA, so a
               // sticky tx_valid still qualifies fresh data here.
               if (ram_tx_valid) begin
                  rdata_r <= ram_dout;
                  err_r   <= 1'b0;
                  state   <= S_RESP;
               end else if (cnt == CW'(TIMEOUT-1)) begin
                  rdata_r <= '0;
                  err_r   <= 1'b1;
                  state   <= S_RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_spi_ram_arbiter
// Self-checking bench for spi_ram_arbiter: directed vector table, hand
// sequences for reset and contention, then randomized traffic compared with
// a transaction-level reference model. Includes a simple SPI RAM model.
// ----------------------------------------------------------------------------
module tb_spi_ram_arbiter;
   localparam int NR = 2;
   localparam int AW = 8;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          busy;
   logic [AW+1:0] ram_din;
   logic          ram_rx_valid;
   logic [AW-1:0] ram_dout;
   logic          ram_tx_valid;

   spi_ram_arbiter_if #(.NUM_REQ(NR), .ADDR_SIZE(AW)) bus ();

   spi_ram_arbiter #(.NUM_REQ(NR), .ADDR_SIZE(AW), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .busy         (busy),
      .ram_din      (ram_din),
      .ram_rx_valid (ram_rx_valid),
      .ram_dout     (ram_dout),
      .ram_tx_valid (ram_tx_valid)
   );

   always #5 clk = ~clk;

   // SPI RAM model: 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd (dout update,
   // tx_valid goes sticky). no_tx suppresses tx_valid for the timeout case.
   logic [7:0] mem [256];
   logic [7:0] wa, ra;
   logic       tx_sticky;
   logic       no_tx = 1'b0;
   assign ram_tx_valid = tx_sticky && !no_tx;

   initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;

   always @(posedge clk) begin
      if (rst) begin
         tx_sticky <= 1'b0;
         ram_dout  <= 8'h00;
      end else if (ram_rx_valid) begin
         case (ram_din[9:8])
            2'b00: wa <= ram_din[7:0];
            2'b01: mem[wa] <= ram_din[7:0];
            2'b10: ra <= ram_din[7:0];
            default: begin
               ram_dout  <= mem[ra];
               tx_sticky <= 1'b1;
            end
         endcase
      end
   end

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      int         r;
      logic       op;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic       no_tx;
      logic [9:0] d0;
      logic [9:0] d1;
      int         done_cyc;
      logic [7:0] rd;
      logic       er;
   } vec_t;

   vec_t vt [6];

   // reference model state for the random phase
   logic [7:0] ref_mem [256];
   int         mlast, free_at, t_start, t_own, t_len, off, idx, gidx;
   logic       active, t_op, found;
   logic [7:0] t_addr, t_wd, exp_rd;
   logic [NR-1:0] exp_gnt, exp_done;
   logic [9:0]    exp_din;
   logic          exp_rx, exp_busy;

   initial begin
      int cyc;
      logic got;

      vt[0] = '{0, 1'b0, 8'h3C, 8'hA5, 1'b0, 10'h03C, 10'h1A5, 3, 8'h00, 1'b0};
      vt[1] = '{0, 1'b0, 8'h10, 8'h5A, 1'b0, 10'h010, 10'h15A, 3, 8'h00, 1'b0};
      vt[2] = '{1, 1'b1, 8'h3C, 8'h00, 1'b0, 10'h23C, 10'h300, 4, 8'hA5, 1'b0};
      vt[3] = '{1, 1'b1, 8'h10, 8'h00, 1'b0, 10'h210, 10'h300, 4, 8'h5A, 1'b0};
      vt[4] = '{0, 1'b1, 8'h20, 8'h00, 1'b1, 10'h220, 10'h300, 3+TO, 8'h00, 1'b1};
      vt[5] = '{1, 1'b1, 8'h3C, 8'h00, 1'b0, 10'h23C, 10'h300, 4, 8'hA5, 1'b0};

      bus.req   = '0;
      bus.op    = '0;
      bus.addr  = '0;
      bus.wdata = '0;

      // reset state, with requests pending during reset
      repeat (2) @(posedge clk);
      #1 bus.req = 2'b11;
      @(negedge clk);
      chk("rst_gnt", 32'(bus.gnt), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_rdata", 32'(bus.rdata), 0);
      chk("rst_err", 32'(bus.err), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_din", 32'(ram_din), 0);
      chk("rst_rxv", 32'(ram_rx_valid), 0);
      @(posedge clk);
      #1 bus.req = '0; rst = 1'b0;

      // directed vector table
      for (int v = 0; v < 6; v++) begin
         @(posedge clk);
         #1;
         no_tx = vt[v].no_tx;
         bus.op[vt[v].r] = vt[v].op;
         bus.addr[vt[v].r*AW +: AW]  = vt[v].addr;
         bus.wdata[vt[v].r*AW +: AW] = vt[v].wdata;
         bus.req = '0;
         bus.req[vt[v].r] = 1'b1;
         @(negedge clk);
         chk("vec_gnt", 32'(bus.gnt), 32'(1) << vt[v].r);
         chk("vec_busy0", 32'(busy), 0);
         @(posedge clk);
         #1 bus.req = '0;
         @(negedge clk);
         chk("vec_rxv1", 32'(ram_rx_valid), 1);
         chk("vec_din1", 32'(ram_din), 32'(vt[v].d0));
         chk("vec_busy1", 32'(busy), 1);
         @(negedge clk);
         chk("vec_rxv2", 32'(ram_rx_valid), 1);
         chk("vec_din2", 32'(ram_din), 32'(vt[v].d1));
         cyc = 2;
         got = 1'b0;
         while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (bus.done != '0) got = 1'b1;
            else chk("vec_rxv_idle", 32'(ram_rx_valid), 0);
         end
         chk("vec_done_cyc", 32'(cyc), 32'(vt[v].done_cyc));
         chk("vec_done", 32'(bus.done), 32'(1) << vt[v].r);
         chk("vec_gnt_at_done", 32'(bus.gnt), 0);
         chk("vec_rdata", 32'(bus.rdata), 32'(vt[v].rd));
         chk("vec_err", 32'(bus.err), 32'(vt[v].er));
         @(negedge clk);
         chk("vec_done_clr", 32'(bus.done), 0);
         chk("vec_rdata_hold", 32'(bus.rdata), 32'(vt[v].rd));
         chk("vec_err_hold", 32'(bus.err), 32'(vt[v].er));
      end
      no_tx = 1'b0;

      // reset in CMD_DATA of a read: dropped, no done
      @(posedge clk);
      #1;
      bus.op[0] = 1'b1;
      bus.addr[0 +: AW] = 8'h3C;
      bus.req = 2'b01;
      @(negedge clk);
      chk("mr_gnt", 32'(bus.gnt), 1);
      @(posedge clk);
      #1 bus.req = '0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("mr_in_cmd_data", 32'(ram_din), 32'h300);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("mr_busy", 32'(busy), 0);
      chk("mr_rxv", 32'(ram_rx_valid), 0);
      chk("mr_din", 32'(ram_din), 0);
      chk("mr_done", 32'(bus.done), 0);
      chk("mr_rdata", 32'(bus.rdata), 0);
      chk("mr_err", 32'(bus.err), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("mr_no_done", 32'(bus.done), 0);
         chk("mr_idle", 32'(busy), 0);
      end

      // contention: both requesting writes continuously, requester 0 first
      @(posedge clk);
      #1;
      bus.op = 2'b00;
      bus.addr  = {8'h02, 8'h01};
      bus.wdata = {8'h22, 8'h11};
      bus.req   = 2'b11;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         chk("ct_gnt", 32'(bus.gnt), 32'(1) << (j % 2));
         @(negedge clk);
         chk("ct_din1", 32'(ram_din), (j % 2 == 0) ? 32'h001 : 32'h002);
         @(negedge clk);
         chk("ct_din2", 32'(ram_din), (j % 2 == 0) ? 32'h111 : 32'h122);
         @(negedge clk);
         chk("ct_done", 32'(bus.done), 32'(1) << (j % 2));
         chk("ct_no_gnt", 32'(bus.gnt), 0);
      end
      @(posedge clk);
      #1 bus.req = '0;

      // randomized traffic against a transaction-level model
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
      mlast   = NR - 1;
      free_at = 0;
      active  = 1'b0;
      t_start = 0; t_own = 0; t_len = 0; t_op = 1'b0;
      t_addr  = 0; t_wd = 0; exp_rd = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (active && (c - t_start) >= t_len) active = 1'b0;
         exp_gnt = '0;
         gidx    = -1;
         if (c >= free_at && bus.req != '0) begin
            found = 1'b0;
            for (int k = 1; k <= NR; k++) begin
               idx = (mlast + k) % NR;
               if (!found && bus.req[idx]) begin
                  found = 1'b1;
                  gidx  = idx;
               end
            end
            exp_gnt[gidx] = 1'b1;
            t_start = c;
            t_own   = gidx;
            t_op    = bus.op[gidx];
            t_addr  = bus.addr[gidx*AW +: AW];
            t_wd    = bus.wdata[gidx*AW +: AW];
            t_len   = t_op ? 5 : 4;
            free_at = c + t_len;
            mlast   = gidx;
            active  = 1'b1;
            if (t_op) exp_rd = ref_mem[t_addr];
            else begin
               ref_mem[t_addr] = t_wd;
               exp_rd = 8'h00;
            end
         end
         off      = c - t_start;
         exp_rx   = active && (off == 1 || off == 2);
         exp_din  = 10'h000;
         if (active && off == 1) exp_din = {t_op, 1'b0, t_addr};
         if (active && off == 2) exp_din = t_op ? 10'h300 : {2'b01, t_wd};
         exp_done = '0;
         if (active && off == t_len - 1) exp_done[t_own] = 1'b1;
         exp_busy = active && off >= 1 && off <= t_len - 1;
         chk("rnd_gnt", 32'(bus.gnt), 32'(exp_gnt));
         chk("rnd_done", 32'(bus.done), 32'(exp_done));
         chk("rnd_rxv", 32'(ram_rx_valid), 32'(exp_rx));
         chk("rnd_din", 32'(ram_din), 32'(exp_din));
         chk("rnd_busy", 32'(busy), 32'(exp_busy));
         if (exp_done != '0) begin
            chk("rnd_rdata", 32'(bus.rdata), 32'(exp_rd));
            chk("rnd_err", 32'(bus.err), 0);
         end
         @(posedge clk);
         #1;
         if (gidx >= 0) bus.req[gidx] = 1'b0;
         for (int i = 0; i < NR; i++) begin
            if (!bus.req[i] && $urandom_range(0, 2) == 0) begin
               bus.op[i] = 1'($urandom_range(0, 1));
               bus.addr[i*AW +: AW]  = 8'h40 + 8'($urandom_range(0, 15));
               bus.wdata[i*AW +: AW] = 8'($urandom);
               bus.req[i] = 1'b1;
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
